// File: rtl/axil_cmd_master_pkg.sv
// axil_cmd_pkg: shared state encoding, AXI response codes and command field offsets
// for the command-stream driven AXI4-Lite master.
package axil_cmd_pkg;

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Command word layout is {wr, addr, wdata}
    function automatic int cmd_wr_bit(input int aw, input int dw);
        return aw + dw;
    endfunction

    function automatic int cmd_addr_lsb(input int dw);
        return dw;
    endfunction

endpackage

// File: rtl/axil_cmd_master.sv
// axil_cmd_master: turns each command-stream word into one AXI4-Lite single-beat
// read or write and returns {resp, rdata} on the response stream.
module axil_cmd_master
    import axil_cmd_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESET,
    input  logic [ADDR_WIDTH+DATA_WIDTH:0] S_AXIS_CMD_TDATA,
    input  logic                          S_AXIS_CMD_TVALID,
    output logic                          S_AXIS_CMD_TREADY,
    output logic [DATA_WIDTH+1:0]         M_AXIS_RSP_TDATA,
    output logic                          M_AXIS_RSP_TVALID,
    input  logic                          M_AXIS_RSP_TREADY,
    output logic [ADDR_WIDTH-1:0]         M_AXI_AWADDR,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]         M_AXI_WDATA,
    output logic [3:0]                    M_AXI_WSTRB,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]         M_AXI_ARADDR,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]         M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY
);

    localparam int WR_BIT   = cmd_wr_bit(ADDR_WIDTH, DATA_WIDTH);
    localparam int ADDR_LSB = cmd_addr_lsb(DATA_WIDTH);

    state_t                  r_state;
    logic                    r_aw_done, r_w_done;
    logic                    r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready, r_rsp_valid;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH+1:0]   r_rsp;
    logic                    w_aw_fin, w_w_fin;

    assign S_AXIS_CMD_TREADY = (r_state == IDLE) && !M_AXI_ARESET;
    assign M_AXIS_RSP_TDATA  = r_rsp;
    assign M_AXIS_RSP_TVALID = r_rsp_valid;
    assign M_AXI_AWADDR      = r_addr;
    assign M_AXI_ARADDR      = r_addr;
    assign M_AXI_AWVALID     = r_awvalid;
    assign M_AXI_WDATA       = r_wdata;
    assign M_AXI_WSTRB       = 4'b1111;
    assign M_AXI_WVALID      = r_wvalid;
    assign M_AXI_BREADY      = r_bready;
    assign M_AXI_ARVALID     = r_arvalid;
    assign M_AXI_RREADY      = r_rready;

    // A channel counts as finished if it completed earlier or handshakes this cycle
    assign w_aw_fin = r_aw_done || M_AXI_AWREADY;
    assign w_w_fin  = r_w_done || M_AXI_WREADY;

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            r_state     <= IDLE;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp       <= '0;
        end else begin
            case (r_state)
                IDLE: if (S_AXIS_CMD_TVALID) begin
                    r_addr  <= S_AXIS_CMD_TDATA[ADDR_LSB +: ADDR_WIDTH];
                    r_wdata <= S_AXIS_CMD_TDATA[DATA_WIDTH-1:0];
                    if (S_AXIS_CMD_TDATA[WR_BIT]) begin
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_state   <= WR_REQ;
                    end else begin
                        r_arvalid <= 1'b1;
                        r_state   <= RD_REQ;
                    end
                end
                WR_REQ: begin
                    if (M_AXI_AWREADY) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (M_AXI_WREADY) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_fin && w_w_fin) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_bready  <= 1'b1;
                        r_state   <= WR_RESP;
                    end
                end
                WR_RESP: if (M_AXI_BVALID) begin
                    r_bready    <= 1'b0;
                    r_rsp       <= {M_AXI_BRESP, {DATA_WIDTH{1'b0}}};
                    r_rsp_valid <= 1'b1;
                    r_state     <= RSP;
                end
                RD_REQ: if (M_AXI_ARREADY) begin
                    r_arvalid <= 1'b0;
                    r_rready  <= 1'b1;
                    r_state   <= RD_RESP;
                end
                RD_RESP: if (M_AXI_RVALID) begin
                    r_rready    <= 1'b0;
                    r_rsp       <= {M_AXI_RRESP, M_AXI_RDATA};
                    r_rsp_valid <= 1'b1;
                    r_state     <= RSP;
                end
                RSP: if (M_AXIS_RSP_TREADY) begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/axil_cmd_master.md
# axil_cmd_master

AXI4-Lite initiator driven by a command stream: each accepted command word becomes one AXI4-Lite single-beat read or write on the master port, and the outcome is returned as one response-stream word. It is the bus-master counterpart to the team's AXI4-Lite register slaves, such as the stream FIFO control port. Firmware-less sequencers and test harnesses use it to program and poll those slaves over the same bus.

## Interface
- ADDR_WIDTH, 4, AXI4-Lite address width (byte address)
- DATA_WIDTH, 32, data width; only 32 is supported
- M_AXI_ACLK  in  1  sole clock
- M_AXI_ARESET  in  1  asynchronous, active-high reset
- S_AXIS_CMD_TDATA  in  1+ADDR_WIDTH+DATA_WIDTH  {wr, addr, wdata}; MSB=1 means write; wdata is ignored for reads
- S_AXIS_CMD_TVALID / S_AXIS_CMD_TREADY  in/out  1  command handshake
- M_AXIS_RSP_TDATA  out  2+DATA_WIDTH  {resp[1:0], rdata}; rdata=0 for writes
- M_AXIS_RSP_TVALID / M_AXIS_RSP_TREADY  out/in  1  response handshake
- M_AXI_AWADDR out ADDR_WIDTH; M_AXI_AWVALID out 1; M_AXI_AWREADY in 1
- M_AXI_WDATA out DATA_WIDTH; M_AXI_WSTRB out 4 (constant 4'b1111); M_AXI_WVALID out 1; M_AXI_WREADY in 1
- M_AXI_BRESP in 2; M_AXI_BVALID in 1; M_AXI_BREADY out 1
- M_AXI_ARADDR out ADDR_WIDTH; M_AXI_ARVALID out 1; M_AXI_ARREADY in 1
- M_AXI_RDATA in DATA_WIDTH; M_AXI_RRESP in 2; M_AXI_RVALID in 1; M_AXI_RREADY out 1

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- **IDLE**
  - CMD_TREADY=1.
  - On CMD handshake, latch addr, wdata and wr.
  - Go to WR_REQ if wr=1, else RD_REQ.
- **WR_REQ**
  - AWVALID and WVALID are both asserted from entry.
  - Each is dropped independently on its own handshake; internal flags aw_done and w_done track this.
  - Leave for WR_RESP on the cycle the second of the two completes; simultaneous completion is allowed.
  - AWREADY/WREADY arriving in either order, or in the same cycle, is legal.
- **WR_RESP**
  - BREADY=1.
  - On BVALID, capture BRESP, set the response word to {BRESP, 0} and go to RSP.
- **RD_REQ**
  - ARVALID=1 until ARREADY, then go to RD_RESP.
- **RD_RESP**
  - RREADY=1.
  - On RVALID, capture {RRESP, RDATA} and go to RSP.
- **RSP**
  - RSP_TVALID=1 with stable TDATA until RSP_TREADY, then go to IDLE.
- VALID is never withdrawn before its handshake. Addresses and data stay stable while VALID is high.
- No timeout: the block waits indefinitely on the slave.
- The resp field passes through unmodified; SLVERR/DECERR are reported, never retried.
- Only one transaction is outstanding at a time.

## Timing
- All outputs are registered except CMD_TREADY, which is decoded from the state register.
- Reset values (asynchronous on M_AXI_ARESET):
  - state=IDLE.
  - All VALID/READY outputs are 0, except CMD_TREADY=1 once reset deasserts.
  - AWADDR, ARADDR, WDATA and RSP_TDATA are 0.
- Command accepted at edge N: AWVALID/WVALID (or ARVALID) are high from N+1.
- Against a zero-wait slave, write: AW/W handshake at N+1, BVALID seen at N+2, RSP_TVALID at N+3.
- Against a zero-wait slave, read: AR handshake at N+1, R at N+2, RSP_TVALID at N+3.
- Minimum command-to-command period is 4 cycles, with RSP_TREADY tied high.
- BREADY/RREADY are asserted only in their RESP states. A slave presenting BVALID/RVALID early is simply held off until then.
- Reset mid-transaction:
  - All VALIDs drop immediately.
  - The pending response is discarded.
  - The slave must be reset together with this block.
- RSP back-pressure stalls the block in RSP. No new command is accepted until the response is consumed.

## Structure
- Package axil_cmd_pkg:
  - state enum;
  - RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - cmd field offset functions derived from ADDR_WIDTH/DATA_WIDTH.
- Single module with one FSM and no sub-module. The AW/W split tracking is two flags, not a separate block.

## Test plan
- Write, zero-wait slave:
  - Stimulus: cmd {1, 4'h8, 32'hDEADBEEF}.
  - Required: AWADDR=8 and WDATA=DEADBEEF on the same cycle N+1.
  - Required: rsp {2'b00, 32'h0} with RSP_TVALID at N+3.
- Read, 3-cycle ARREADY delay and 2-cycle RVALID delay:
  - Stimulus: cmd {0, 4'h0, x}; slave returns 32'h12345678.
  - Required: ARVALID is held stable for 4 cycles.
  - Required: rsp {2'b00, 32'h12345678}.
- Write with skewed readies:
  - Stimulus: WREADY 2 cycles before AWREADY, then the reverse order.
  - Required: WVALID drops after its own handshake, AWVALID is held, and exactly one AW beat and one W beat occur.
- Error response and back-pressure:
  - Stimulus: slave returns BRESP=2'b10; RSP_TREADY is held low for 5 cycles.
  - Required: RSP_TDATA={2'b10, 0} stable throughout.
  - Required: CMD_TREADY=0 until the response handshake.
- Reset mid-read:
  - Stimulus: M_AXI_ARESET asserted while in RD_RESP.
  - Required: ARVALID, RREADY and RSP_TVALID are 0 within the same cycle.
  - Required: after release, CMD_TREADY=1 and no stale response appears.
- Random stream:
  - Stimulus: 1000 random read/write commands against a register-file slave model with random wait states.
  - Required: every read returns the last value written to that address.
  - Required: response count equals command count.
